// File: rtl/pam_meas_ctrl.sv
// Measurement sequencer: flush the averaging window, collect 2^AVG_LOG2 period/phase pairs, hand the mean out on valid/ready.
// Optional macro PAM_MEAS_CTRL_STATS_EN adds a saturating reject_cnt output.
module pam_meas_ctrl #(
    parameter int AVG_LOG2   = 2,
    parameter int TIMEOUT    = 2000000,
    parameter int FLUSH_CYC  = 16,
    parameter int PERIOD_MIN = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        continuous,
    output logic        dp_clear,
    input  logic        dp_time_point,
    input  logic [20:0] dp_period,
    input  logic        dp_phase_mark,
    input  logic [9:0]  dp_phase_time,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [20:0] res_period,
    output logic [9:0]  res_phase,
    output logic        busy,
    output logic        timeout_err
`ifdef PAM_MEAS_CTRL_STATS_EN
    ,
    output logic [7:0]  reject_cnt
`endif
);

    localparam int N     = 1 << AVG_LOG2;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int FL_W  = $clog2(FLUSH_CYC + 1);
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int PA_W  = 21 + AVG_LOG2;
    localparam int PH_W  = 10 + AVG_LOG2;

    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        WAIT_P,
        WAIT_PH,
        GET_PH,
        OUT
    } state_t;

    state_t            state, state_nxt;
    logic              tp_q;
    logic [WD_W-1:0]   wdog;
    logic [FL_W-1:0]   fcnt;
    logic [CNT_W-1:0]  cnt;
    logic [PA_W-1:0]   acc_p;
    logic [PH_W-1:0]   acc_ph;
    logic [PH_W-1:0]   ph_sum;

    logic tp_rise, period_ok, wd_last;
    logic acc_clr, p_add, ph_add, res_load, to_set, err_clr;

    // Truncating mean: drop the AVG_LOG2 fraction bits, no rounding.
    function automatic logic [20:0] avg_period(input logic [PA_W-1:0] acc);
        return 21'(acc >> AVG_LOG2);
    endfunction

    function automatic logic [9:0] avg_phase(input logic [PH_W-1:0] acc);
        return 10'(acc >> AVG_LOG2);
    endfunction

    assign tp_rise   = dp_time_point & ~tp_q;
    assign period_ok = (dp_period >= 21'(PERIOD_MIN));
    assign wd_last   = (wdog == WD_LAST);
    assign ph_sum    = acc_ph + PH_W'(dp_phase_time);

    always_comb begin
        state_nxt = state;
        dp_clear  = 1'b0;
        res_valid = 1'b0;
        busy      = (state != IDLE);
        acc_clr   = 1'b0;
        p_add     = 1'b0;
        ph_add    = 1'b0;
        res_load  = 1'b0;
        to_set    = 1'b0;
        err_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FLUSH;
                    acc_clr   = 1'b1;
                    err_clr   = 1'b1;
                end
            end
            FLUSH: begin
                dp_clear = 1'b1;
                if (fcnt == FL_LAST) state_nxt = WAIT_P;
            end
            WAIT_P: begin
                if (tp_rise && period_ok) begin
                    p_add     = 1'b1;
                    state_nxt = WAIT_PH;
                end else if (wd_last) begin
                    to_set    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_PH: begin
                if (dp_phase_mark) begin
                    state_nxt = GET_PH;
                end else if (wd_last) begin
                    to_set    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            GET_PH: begin
                // dp_phase_time is valid one cycle after the mark
                ph_add = 1'b1;
                if (cnt == CNT_LAST) begin
                    res_load  = 1'b1;
                    state_nxt = OUT;
                end else begin
                    state_nxt = WAIT_P;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    if (continuous) begin
                        acc_clr   = 1'b1;
                        state_nxt = WAIT_P;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // abort overrides everything, including a same-cycle start or timeout
        if (abort) begin
            state_nxt = IDLE;
            acc_clr   = 1'b0;
            p_add     = 1'b0;
            ph_add    = 1'b0;
            res_load  = 1'b0;
            to_set    = 1'b0;
            err_clr   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            tp_q        <= 1'b0;
            wdog        <= '0;
            fcnt        <= '0;
            cnt         <= '0;
            acc_p       <= '0;
            acc_ph      <= '0;
            res_period  <= '0;
            res_phase   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            tp_q  <= dp_time_point;
            // Accepted events always change state, so staying put means still waiting.
            if ((state == WAIT_P || state == WAIT_PH) && state_nxt == state)
                wdog <= wdog + 1'b1;
            else
                wdog <= '0;
            fcnt <= (state == FLUSH) ? fcnt + 1'b1 : '0;
            if (acc_clr) begin
                cnt    <= '0;
                acc_p  <= '0;
                acc_ph <= '0;
            end else begin
                if (p_add) acc_p <= acc_p + PA_W'(dp_period);
                if (ph_add) begin
                    acc_ph <= ph_sum;
                    cnt    <= cnt + 1'b1;
                end
            end
            if (res_load) begin
                res_period <= avg_period(acc_p);
                res_phase  <= avg_phase(ph_sum);
            end
            if (err_clr)
                timeout_err <= 1'b0;
            else if (to_set)
                timeout_err <= 1'b1;
        end
    end

`ifdef PAM_MEAS_CTRL_STATS_EN
    logic period_reject;
    assign period_reject = (state == WAIT_P) && tp_rise && !period_ok && !abort;

    always_ff @(posedge clk) begin
        if (!rst_n)
            reject_cnt <= 8'd0;
        else if (acc_clr)
            reject_cnt <= 8'd0;
        else if (period_reject && reject_cnt != 8'hFF)
            reject_cnt <= reject_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_pam_meas_ctrl.sv
// Bench for pam_meas_ctrl: directed scenarios plus random traffic against a queue-based reference model.
module tb_pam_meas_ctrl;

    localparam int AVG_LOG2   = 2;
    localparam int N          = 4;
    localparam int TIMEOUT    = 500;
    localparam int FLUSH_CYC  = 16;
    localparam int PERIOD_MIN = 16;

    logic        clk, rst_n, start, abort, continuous;
    logic        dp_clear, dp_time_point, dp_phase_mark;
    logic [20:0] dp_period;
    logic [9:0]  dp_phase_time;
    logic        res_valid, res_ready, busy, timeout_err;
    logic [20:0] res_period;
    logic [9:0]  res_phase;
`ifdef PAM_MEAS_CTRL_STATS_EN
    logic [7:0]  reject_cnt;
`endif

    int tests = 0;
    int fails = 0;

    pam_meas_ctrl #(
        .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT), .FLUSH_CYC(FLUSH_CYC), .PERIOD_MIN(PERIOD_MIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .continuous(continuous),
        .dp_clear(dp_clear), .dp_time_point(dp_time_point), .dp_period(dp_period),
        .dp_phase_mark(dp_phase_mark), .dp_phase_time(dp_phase_time),
        .res_valid(res_valid), .res_ready(res_ready), .res_period(res_period),
        .res_phase(res_phase), .busy(busy), .timeout_err(timeout_err)
`ifdef PAM_MEAS_CTRL_STATS_EN
        , .reject_cnt(reject_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_FLUSH, M_WP, M_WPH, M_GET, M_OUT} mode_t;
    mode_t  mode = M_IDLE;
    longint per_q[$];
    longint ph_q[$];
    int     flush_left, age, m_rej;
    bit     prev_tp, m_terr, model_live;
    longint exp_per, exp_ph;

    always @(posedge clk) begin : model
        bit rise;
        longint sp, sh;
        rise = dp_time_point && !prev_tp;
        if (!rst_n) begin
            mode = M_IDLE; per_q.delete(); ph_q.delete();
            prev_tp = 0; m_terr = 0; m_rej = 0; exp_per = 0; exp_ph = 0; age = 0;
            model_live = 1;
        end else begin
            prev_tp = dp_time_point;
            if (abort) mode = M_IDLE;
            else case (mode)
                M_IDLE: if (start) begin
                    mode = M_FLUSH; flush_left = FLUSH_CYC;
                    per_q.delete(); ph_q.delete(); m_terr = 0; m_rej = 0;
                end
                M_FLUSH: begin
                    flush_left--;
                    if (flush_left == 0) begin mode = M_WP; age = 0; end
                end
                M_WP: begin
                    if (rise && dp_period >= PERIOD_MIN) begin
                        per_q.push_back(dp_period); mode = M_WPH; age = 0;
                    end else begin
                        if (rise && m_rej < 255) m_rej++;
                        age++;
                        if (age == TIMEOUT) begin m_terr = 1; mode = M_IDLE; end
                    end
                end
                M_WPH: begin
                    if (dp_phase_mark) mode = M_GET;
                    else begin
                        age++;
                        if (age == TIMEOUT) begin m_terr = 1; mode = M_IDLE; end
                    end
                end
                M_GET: begin
                    ph_q.push_back(dp_phase_time);
                    if (ph_q.size() == N) begin
                        sp = 0; sh = 0;
                        foreach (per_q[i]) sp += per_q[i];
                        foreach (ph_q[i]) sh += ph_q[i];
                        exp_per = sp / N; exp_ph = sh / N;
                        mode = M_OUT;
                    end else begin
                        mode = M_WP; age = 0;
                    end
                end
                M_OUT: if (res_ready) begin
                    if (continuous) begin
                        per_q.delete(); ph_q.delete(); m_rej = 0; mode = M_WP; age = 0;
                    end else mode = M_IDLE;
                end
                default: mode = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("busy", busy, mode != M_IDLE);
            chk("dp_clear", dp_clear, mode == M_FLUSH);
            chk("res_valid", res_valid, mode == M_OUT);
            chk("res_period", res_period, exp_per[31:0]);
            chk("res_phase", res_phase, exp_ph[31:0]);
            chk("timeout_err", timeout_err, m_terr);
`ifdef PAM_MEAS_CTRL_STATS_EN
            chk("reject_cnt", reject_cnt, m_rej);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic start_and_flush();
        do_start();
        repeat (FLUSH_CYC) tick();
    endtask

    task automatic send_pair(input int per, input int ph);
        dp_period = 21'(per); dp_time_point = 1; tick();
        dp_time_point = 0; dp_period = 21'($urandom); tick();
        dp_phase_mark = 1; tick();
        dp_phase_mark = 0; dp_phase_time = 10'(ph); tick();
        dp_phase_time = 10'($urandom);
    endtask

    task automatic send_reject(input int per);
        dp_period = 21'(per); dp_time_point = 1; tick();
        dp_time_point = 0; tick();
    endtask

    task automatic handshake();
        res_ready = 1; tick(); res_ready = 0;
    endtask

    initial begin
        logic [20:0] hold_p;
        logic [9:0]  hold_ph;
        int n;
        rst_n = 0; start = 0; abort = 0; continuous = 0; res_ready = 0;
        dp_time_point = 0; dp_phase_mark = 0; dp_period = '0; dp_phase_time = '0;
        repeat (3) tick();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_period", res_period, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst_n = 1; tick();

        // plain run, N = 4
        start_and_flush();
        send_pair(1000, 100); send_pair(1000, 102); send_pair(1000, 98); send_pair(1000, 100);
        #1;
        chk("t1_valid_latency", res_valid, 1);
        chk("t1_res_period", res_period, 1000);
        chk("t1_res_phase", res_phase, 100);
        chk("t1_model_period", exp_per[31:0], 1000);
        handshake(); #1;
        chk("t1_idle_after_hs", busy, 0);

        // implausible period rejected
        start_and_flush();
        send_reject(10);
        send_pair(1000, 50); send_pair(1001, 50); send_pair(999, 50); send_pair(1004, 50);
        #1;
        chk("t2_res_period", res_period, 1001);
        chk("t2_res_phase", res_phase, 50);
`ifdef PAM_MEAS_CTRL_STATS_EN
        chk("t2_reject_cnt", reject_cnt, 1);
`endif
        handshake();

        // watchdog: no datapath events
        do_start();
        n = 0;
        while (!timeout_err && n < 2000) begin tick(); n++; end
        #1;
        chk("t3_timeout_cycles", n, FLUSH_CYC + TIMEOUT);
        chk("t3_timeout_idle", busy, 0);
        chk("t3_timeout_err", timeout_err, 1);

        // back-pressure on the result
        start_and_flush();
        repeat (4) send_pair($urandom_range(PERIOD_MIN, 2097151), $urandom_range(0, 1023));
        #1;
        hold_p = res_period; hold_ph = res_phase;
        chk("t4_err_cleared", timeout_err, 0);
        repeat (20) begin
            tick(); #1;
            chk("t4_hold_valid", res_valid, 1);
            chk("t4_hold_period", res_period, hold_p);
            chk("t4_hold_phase", res_phase, hold_ph);
        end
        handshake(); #1;
        chk("t4_idle", busy, 0);

        // continuous mode: second run without flush
        continuous = 1;
        start_and_flush();
        repeat (4) send_pair(2000, 10);
        #1; chk("t5_first_period", res_period, 2000);
        handshake(); #1;
        chk("t5_no_flush", dp_clear, 0);
        chk("t5_still_busy", busy, 1);
        repeat (4) send_pair(3000, 20);
        #1;
        chk("t5_second_period", res_period, 3000);
        chk("t5_second_phase", res_phase, 20);
        continuous = 0;
        handshake(); #1;
        chk("t5_idle", busy, 0);

        // abort in WAIT_PH, then a fresh run
        start_and_flush();
        send_pair(5000, 500); send_pair(5000, 500);
        dp_period = 21'd7000; dp_time_point = 1; tick();
        dp_time_point = 0; abort = 1; tick(); abort = 0; #1;
        chk("t6_abort_idle", busy, 0);
        do_start();
        n = 0;
        repeat (40) begin
            if (dp_clear) n++;
            tick();
        end
        chk("t6_flush_cycles", n, FLUSH_CYC);
        repeat (4) send_pair(1200, 40);
        #1;
        chk("t6_res_period", res_period, 1200);
        chk("t6_res_phase", res_phase, 40);
        handshake();

        // random traffic, model checks every cycle
        for (int c = 0; c < 6000; c++) begin
            rst_n         = ($urandom % 1500) != 0;
            start         = ($urandom % 16) == 0;
            abort         = ($urandom % 300) == 0;
            if (($urandom % 6) == 0) dp_time_point = ~dp_time_point;
            dp_period     = (($urandom % 4) == 0) ? 21'($urandom_range(0, 19)) : 21'($urandom);
            dp_phase_mark = ($urandom % 8) == 0;
            dp_phase_time = 10'($urandom);
            res_ready     = ($urandom % 3) == 0;
            if (($urandom % 200) == 0) continuous = 1'($urandom);
            tick();
        end
        rst_n = 1; start = 0; abort = 0; res_ready = 0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pam_meas_ctrl.md
Name: pam_meas_ctrl

Overview:
Sequencer for the pulse-period/phase measurement datapath (moving-average peak detector).
- Flushes the averaging window, then collects 2^AVG_LOG2 period/phase measurement pairs.
- Rejects implausible periods and guards every wait with a watchdog.
- Presents averaged results on a valid/ready interface to the frame packer.
- Supports single-shot and continuous operation.

Parameters:
AVG_LOG2, 2, log2 of measurement pairs averaged per result (N = 4)
TIMEOUT, 2000000, watchdog limit in clk cycles per awaited event
FLUSH_CYC, 16, cycles dp_clear is held (moving-average window depth)
PERIOD_MIN, 16, smallest accepted dp_period; smaller values are rejected

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  single-cycle request to begin a measurement run
abort  in  1  single-cycle request to cancel the run
continuous  in  1  1 = restart collection automatically after each result handshake
dp_clear  out  1  held high to flush the datapath window
dp_time_point  in  1  datapath period-ready level
dp_period  in  21  datapath period value
dp_phase_mark  in  1  datapath phase-crossing pulse
dp_phase_time  in  10  datapath phase timer; valid the cycle after dp_phase_mark
res_valid  out  1  result available
res_ready  in  1  consumer accepts the result
res_period  out  21  averaged period
res_phase  out  10  averaged phase
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky watchdog flag; cleared by the next accepted start

Behaviour:
Reset (rst_n=0 at a clk edge):
- State goes to IDLE.
- Outputs after reset: dp_clear=0, res_valid=0, res_period=0, res_phase=0, busy=0, timeout_err=0.
- Accumulators, sample counter and watchdog are cleared.
- Applies from any state, including mid-run.

States and transitions:
- IDLE: start=1 -> FLUSH; clears accumulators, sample count and timeout_err.
- FLUSH: dp_clear=1 for exactly FLUSH_CYC cycles, then -> WAIT_P.
- WAIT_P: waits for a dp_time_point rising edge (detected against a registered copy).
  - dp_period < PERIOD_MIN: value discarded; stay in WAIT_P.
  - Otherwise: add dp_period to a (21+AVG_LOG2)-bit accumulator -> WAIT_PH.
- WAIT_PH: on dp_phase_mark, sample dp_phase_time on the following cycle.
  - Add the sample to a (10+AVG_LOG2)-bit accumulator and increment the sample count.
  - Count = 2^AVG_LOG2 -> OUT; otherwise -> WAIT_P.
- OUT:
  - res_valid=1 the cycle after the final phase sample.
  - res_period = period accumulator >> AVG_LOG2, truncated (no rounding); res_phase likewise.
  - res_period and res_phase stay stable while res_valid=1 and res_ready=0.
  - Handshake completes on res_valid & res_ready.
  - After handshake: continuous=1 -> WAIT_P with accumulators and count cleared, no flush; continuous=0 -> IDLE.

Watchdog:
- Counts in WAIT_P and WAIT_PH; reset on state entry and on each accepted event. Rejected periods do not reset it.
- Reaching TIMEOUT: timeout_err=1, -> IDLE, no result produced.

Boundary rules:
- abort: -> IDLE next cycle from any state; res_valid drops; no result; timeout_err unchanged.
- abort and start in the same cycle: abort wins.
- start while busy is ignored.
- dp_phase_mark in WAIT_P is ignored. A time_point edge arriving with a phase_mark while in WAIT_P takes the period only.
- A dp_time_point edge in WAIT_PH is ignored; no re-pairing.

Optional Feature:
PAM_MEAS_CTRL_STATS_EN:
- Defined: adds output reject_cnt [7:0], a saturating count (stops at 255) of rejected periods in the current run. Cleared when start is accepted and on continuous restart; readable while res_valid=1.
- Undefined: the port and logic are absent; rejects are discarded silently.

Test Plan:
1. start; 4 pairs, period 1000 each, phase 100/102/98/100 -> res_valid 1 cycle after the 4th phase sample; res_period=1000, res_phase=100; busy=0 after handshake.
2. Periods 10, 1000, 1001, 999, 1004 with phase 50 each -> the 10 is rejected (reject_cnt=1 when enabled); res_period=1001, res_phase=50.
3. TIMEOUT=500, start, no datapath events -> timeout_err=1 exactly 500 cycles after entering WAIT_P; state IDLE; res_valid never asserted.
4. Result pending, res_ready=0 for 20 cycles -> res_valid, res_period, res_phase stable; handshake on cycle 21; IDLE when continuous=0.
5. continuous=1, two full runs (periods 2000, then 3000) -> second result 3000 with no dp_clear pulse between runs.
6. abort during WAIT_PH after 2 pairs; then start again -> IDLE next cycle; new run begins with FLUSH (16 dp_clear cycles); the earlier pairs do not contribute to the result.
